bus_sync_deglitch: RTL and testbench
====================================

Name: bus_sync_deglitch

Overview:
Multi-bit level synchronizer with a stability qualifier, for the PCIe sync library. Each data_in bit passes through its own NUMSTGS-flop chain on clk. The synchronized bus is committed to data_out only after it has held the same value for STBLCNT consecutive cycles. This filters skewed or glitching multi-bit transitions, such as quasi-static config or status buses from another domain. Outputs are a validity flag, a change-strobe pulse and an instability indicator.

Parameters:
NUMSTGS, 2, synchronizer flop stages per bit; must be at least 2, else elaboration error.
DATAWTH, 8, bus width in bits; must be at least 1.
STBLCNT, 3, consecutive equal synchronized samples required before commit; must be at least 1, else elaboration error.
RSTVAL, '0, DATAWTH-bit reset value of the sync chain, the candidate register and data_out.

Ports:
clk  input  1  destination-domain clock; the only clock.
rst_n  input  1  reset, synchronous, active-low.
data_in  input  DATAWTH  asynchronous source bus.
data_out  output  DATAWTH  qualified, synchronized bus.
data_vld  output  1  sticky; high once the first stable value has been committed.
chg_pulse  output  1  one-cycle strobe, asserted when data_out takes a new, different value.
unstable  output  1  high while the candidate has not yet reached STBLCNT stable cycles.

Behaviour:
- Reset:
  - rst_n low at a clk edge has priority over everything else.
  - Sync chain = RSTVAL, cand = RSTVAL, cnt = 0, data_out = RSTVAL.
  - data_vld = 0, chg_pulse = 0, unstable = 1.
  - Reset asserted mid-count discards any in-progress candidate.
- Sync stage: per bit, an NUMSTGS-flop shift chain. s = last stage. No cross-bit coherence is assumed.
- Qualifier registers: cand (DATAWTH bits) and cnt (width $clog2(STBLCNT+1)).
- Each edge, evaluated on pre-edge values:
  - If s != cand: cand <= s, cnt <= 0.
  - Else if cnt < STBLCNT: cnt <= cnt+1.
  - Else: cnt holds. The counter saturates and never wraps.
- Commit, on every edge where pre-edge cnt == STBLCNT:
  - data_out <= cand, data_vld <= 1.
  - chg_pulse <= (cand != data_out).
  - On all other edges chg_pulse <= 0.
  - A held stable value re-commits harmlessly with no pulse.
- unstable = (cnt != STBLCNT), decoded combinationally from the cnt register only.
- Latency, for a data_in change sampled at edge 1 and then held:
  - s changes at edge NUMSTGS.
  - cand updates at edge NUMSTGS+1.
  - cnt reaches STBLCNT at edge NUMSTGS+1+STBLCNT.
  - data_out and chg_pulse update at edge NUMSTGS+STBLCNT+2. Default parameters give 7.
- Glitch rule: a synchronized value held for L cycles commits only if L >= STBLCNT+1. Shorter excursions never reach data_out and produce no pulse.
- Mismatch while saturated: cnt returns to 0 and unstable rises on the next cycle. data_out holds its last committed value.
- After reset with data_in constant = RSTVAL: cnt hits STBLCNT at edge STBLCNT after reset release, and data_vld rises at the following edge. chg_pulse stays 0.
- data_vld stays low until the first commit and then remains high until reset.

Decomposition:
- Package pcie_sync_pkg: localparam helper for the cnt width, plus elaboration-check macros and functions shared by the sync library.
- One sub-module, sync_bit_rst: a single-bit NUMSTGS flop chain with a synchronous active-low reset value input. It is instantiated DATAWTH times in a generate loop.
- The qualifier FSM/counter lives in the top module.

Test Plan:
- Reset, then data_in held at 8'h00 (RSTVAL 0) -> data_vld rises at edge 4 after release; data_out=8'h00; chg_pulse never asserts; unstable falls at edge 3.
- After vld, step data_in 8'h00->8'hA5 sampled at edge 1 -> data_out=8'hA5 and chg_pulse high for exactly one cycle at edge 7; unstable high from edge 4 until edge 6.
- 3-cycle glitch 8'h00->8'hFF->8'h00 with STBLCNT=3 -> data_out stays 8'h00, no chg_pulse. Repeat with 4 cycles -> data_out becomes 8'hFF, then 8'h00, with two separate pulses.
- Skewed transition 8'h0F->8'hF0 with bits arriving one cycle apart (intermediate 8'hFF for 1 cycle) -> data_out goes directly 8'h0F->8'hF0, never 8'hFF, with one pulse.
- rst_n asserted for one cycle while cnt=2 on a pending 8'h3C -> all outputs return to reset values the next cycle; 8'h3C (still driven) later commits at normal latency after release.
- Parameter sweep NUMSTGS=3, STBLCNT=1, DATAWTH=1: 0->1 step -> data_out updates at edge 6; 1-cycle pulse suppressed.

Source files
------------

// File: rtl/pcie_sync_pkg.sv
// Shared helpers for the PCIe sync library: counter sizing and elaboration-time
// parameter legality checks used by the synchronizer blocks.
package pcie_sync_pkg;

    localparam int MIN_SYNC_STAGES  = 2;
    localparam int MIN_STABLE_COUNT = 1;
    localparam int MIN_BUS_WIDTH    = 1;

    // Width of a counter that must hold every value 0..stblcnt inclusive.
    function automatic int cnt_width(input int stblcnt);
        return (stblcnt < 1) ? 1 : $clog2(stblcnt + 1);
    endfunction

    function automatic bit param_at_least(input int val, input int min_val);
        return val >= min_val;
    endfunction

endpackage

// File: rtl/sync_bit_rst.sv
// Single-bit multi-flop level synchronizer with a synchronous active-low reset
// that loads a caller-supplied reset value into every stage.
module sync_bit_rst #(
    parameter int NUMSTGS = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rst_val_i,
    input  logic d_i,
    output logic q_o
);

    logic [NUMSTGS-1:0] chain_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chain_q <= {NUMSTGS{rst_val_i}};
        end else begin
            chain_q <= {chain_q[NUMSTGS-2:0], d_i};
        end
    end

    assign q_o = chain_q[NUMSTGS-1];

endmodule

// File: rtl/bus_sync_deglitch.sv
// Multi-bit level synchronizer that only commits the synchronized bus after it
// has held one value for STBLCNT consecutive cycles, filtering skew and glitches.
module bus_sync_deglitch
    import pcie_sync_pkg::*;
#(
    parameter int                 NUMSTGS = 2,
    parameter int                 DATAWTH = 8,
    parameter int                 STBLCNT = 3,
    parameter logic [DATAWTH-1:0] RSTVAL  = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [DATAWTH-1:0] data_in,
    output logic [DATAWTH-1:0] data_out,
    output logic               data_vld,
    output logic               chg_pulse,
    output logic               unstable
);

    localparam int               CNT_W   = cnt_width(STBLCNT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STBLCNT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    if (!param_at_least(NUMSTGS, MIN_SYNC_STAGES)) begin : g_bad_numstgs
        $error("bus_sync_deglitch: NUMSTGS must be at least 2");
    end
    if (!param_at_least(STBLCNT, MIN_STABLE_COUNT)) begin : g_bad_stblcnt
        $error("bus_sync_deglitch: STBLCNT must be at least 1");
    end
    if (!param_at_least(DATAWTH, MIN_BUS_WIDTH)) begin : g_bad_datawth
        $error("bus_sync_deglitch: DATAWTH must be at least 1");
    end

    logic [DATAWTH-1:0] sync_s;

    // Bits are synchronized independently; the qualifier below absorbs any skew.
    for (genvar gi = 0; gi < DATAWTH; gi++) begin : g_sync
        sync_bit_rst #(
            .NUMSTGS (NUMSTGS)
        ) u_sync_bit (
            .clk       (clk),
            .rst_n     (rst_n),
            .rst_val_i (RSTVAL[gi]),
            .d_i       (data_in[gi]),
            .q_o       (sync_s[gi])
        );
    end

    logic [DATAWTH-1:0] cand_q, cand_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATAWTH-1:0] dout_q, dout_d;
    logic               vld_q, vld_d;
    logic               chg_q, chg_d;

    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        dout_d = dout_q;
        vld_d  = vld_q;
        chg_d  = 1'b0;

        if (sync_s != cand_q) begin
            cand_d = sync_s;
            cnt_d  = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
        end

        // A saturated counter re-commits every cycle; the pulse fires only on a real change.
        if (cnt_q == CNT_MAX) begin
            dout_d = cand_q;
            vld_d  = 1'b1;
            chg_d  = (cand_q != dout_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cand_q <= RSTVAL;
            cnt_q  <= '0;
            dout_q <= RSTVAL;
            vld_q  <= 1'b0;
            chg_q  <= 1'b0;
        end else begin
            cand_q <= cand_d;
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
            vld_q  <= vld_d;
            chg_q  <= chg_d;
        end
    end

    assign data_out  = dout_q;
    assign data_vld  = vld_q;
    assign chg_pulse = chg_q;
    assign unstable  = (cnt_q != CNT_MAX);

endmodule

// File: tb/tb_bus_sync_deglitch.sv
// Bench for bus_sync_deglitch: default 8-bit instance plus a NUMSTGS=3/STBLCNT=1/1-bit
// instance, checked each cycle against a run-length model and directed literals.
module tb_bus_sync_deglitch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [7:0] din_a, dout_a;
    logic       vld_a, chg_a, unst_a;
    logic [0:0] din_b, dout_b;
    logic       vld_b, chg_b, unst_b;

    bus_sync_deglitch #(.NUMSTGS(2), .DATAWTH(8), .STBLCNT(3), .RSTVAL(8'h00)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .data_in(din_a), .data_out(dout_a),
        .data_vld(vld_a), .chg_pulse(chg_a), .unstable(unst_a)
    );

    bus_sync_deglitch #(.NUMSTGS(3), .DATAWTH(1), .STBLCNT(1), .RSTVAL(1'b0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .data_in(din_b), .data_out(dout_b),
        .data_vld(vld_b), .chg_pulse(chg_b), .unstable(unst_b)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h want %h at t=%0t", name, got, want, $time);
        end
    endtask

    // Model: a value commits once the synchronized stream showed it on STBLCNT+1
    // consecutive edges (the reset edge counts as one showing RSTVAL).
    int         ns [2] = '{2, 3};
    int         sc [2] = '{3, 1};
    logic [7:0] chain_m [2][8];
    logic [7:0] hist_m  [2][8];
    int         hist_n  [2];
    logic [7:0] exp_out [2];
    logic       exp_vld [2];
    logic       exp_chg [2];
    logic       exp_unst[2];
    bit         model_on = 1'b0;

    function automatic logic stable_run(input int i);
        if (hist_n[i] < sc[i] + 1) return 1'b0;
        for (int j = 1; j <= sc[i]; j++)
            if (hist_m[i][j] !== hist_m[i][0]) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        logic [7:0] din_m [2];
        logic [7:0] s_pre;
        din_m[0] = din_a;
        din_m[1] = {7'b0, din_b};
        if (!rst_n) model_on = 1'b1;
        if (model_on) begin
            for (int i = 0; i < 2; i++) begin
                if (!rst_n) begin
                    for (int j = 0; j < 8; j++) begin
                        chain_m[i][j] = 8'h00;
                        hist_m[i][j]  = 8'h00;
                    end
                    hist_n[i]  = 1;
                    exp_out[i] = 8'h00;
                    exp_vld[i] = 1'b0;
                    exp_chg[i] = 1'b0;
                end else begin
                    s_pre = chain_m[i][ns[i]-1];
                    if (stable_run(i)) begin
                        exp_chg[i] = (hist_m[i][0] != exp_out[i]);
                        exp_out[i] = hist_m[i][0];
                        exp_vld[i] = 1'b1;
                    end else begin
                        exp_chg[i] = 1'b0;
                    end
                    for (int j = 7; j > 0; j--) hist_m[i][j] = hist_m[i][j-1];
                    hist_m[i][0] = s_pre;
                    if (hist_n[i] < 8) hist_n[i]++;
                    for (int j = 7; j > 0; j--) chain_m[i][j] = chain_m[i][j-1];
                    chain_m[i][0] = din_m[i];
                end
                exp_unst[i] = !stable_run(i);
            end
            #1;
            check("model_dout_a", dout_a, exp_out[0]);
            check("model_vld_a", {7'b0, vld_a}, {7'b0, exp_vld[0]});
            check("model_chg_a", {7'b0, chg_a}, {7'b0, exp_chg[0]});
            check("model_unst_a", {7'b0, unst_a}, {7'b0, exp_unst[0]});
            check("model_dout_b", {7'b0, dout_b}, exp_out[1]);
            check("model_vld_b", {7'b0, vld_b}, {7'b0, exp_vld[1]});
            check("model_chg_b", {7'b0, chg_b}, {7'b0, exp_chg[1]});
            check("model_unst_b", {7'b0, unst_b}, {7'b0, exp_unst[1]});
        end
    end

    int   pulses_a, pulses_b;
    logic saw_ff;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            tick();
            if (chg_a) pulses_a++;
            if (dout_a == 8'hFF) saw_ff = 1'b1;
            if (chg_b) pulses_b++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        din_a = 8'h00;
        din_b = 1'b0;
        tick();
        tick();
        check("rst_dout", dout_a, 8'h00);
        check("rst_vld", {7'b0, vld_a}, 8'h00);
        check("rst_chg", {7'b0, chg_a}, 8'h00);
        check("rst_unst", {7'b0, unst_a}, 8'h01);
        $display("txn reset: dout=%h vld=%b unstable=%b", dout_a, vld_a, unst_a);

        rst_n = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            tick();
            if (e == 2) check("post_rst_unst_e2", {7'b0, unst_a}, 8'h01);
            if (e == 3) check("post_rst_unst_e3", {7'b0, unst_a}, 8'h00);
            if (e == 3) check("post_rst_vld_e3", {7'b0, vld_a}, 8'h00);
            if (e == 4) check("post_rst_vld_e4", {7'b0, vld_a}, 8'h01);
            if (e == 4) check("post_rst_dout_e4", dout_a, 8'h00);
        end
        $display("txn first_commit: dout=%h vld=%b", dout_a, vld_a);
        repeat (4) tick();

        din_a = 8'hA5;
        for (int e = 1; e <= 8; e++) begin
            tick();
            if (e == 4 || e == 5) check("step_unst_high", {7'b0, unst_a}, 8'h01);
            if (e == 6) check("step_unst_e6", {7'b0, unst_a}, 8'h00);
            if (e == 6) check("step_dout_e6", dout_a, 8'h00);
            if (e == 7) check("step_dout_e7", dout_a, 8'hA5);
            if (e == 7) check("step_chg_e7", {7'b0, chg_a}, 8'h01);
            if (e == 8) check("step_chg_e8", {7'b0, chg_a}, 8'h00);
        end
        $display("txn step_A5: dout=%h", dout_a);

        din_a = 8'h00;
        repeat (12) tick();
        pulses_a = 0; saw_ff = 1'b0;
        din_a = 8'hFF; run(3);
        din_a = 8'h00; run(12);
        check("glitch3_pulses", 8'(pulses_a), 8'd0);
        check("glitch3_dout", dout_a, 8'h00);
        check("glitch3_saw_ff", {7'b0, saw_ff}, 8'h00);
        $display("txn glitch3: dout=%h pulses=%0d", dout_a, pulses_a);

        pulses_a = 0; saw_ff = 1'b0;
        din_a = 8'hFF; run(4);
        din_a = 8'h00; run(12);
        check("glitch4_pulses", 8'(pulses_a), 8'd2);
        check("glitch4_saw_ff", {7'b0, saw_ff}, 8'h01);
        check("glitch4_dout", dout_a, 8'h00);
        $display("txn glitch4: dout=%h pulses=%0d", dout_a, pulses_a);

        din_a = 8'h0F;
        repeat (12) tick();
        pulses_a = 0; saw_ff = 1'b0;
        din_a = 8'hFF; run(1);
        din_a = 8'hF0; run(12);
        check("skew_pulses", 8'(pulses_a), 8'd1);
        check("skew_saw_ff", {7'b0, saw_ff}, 8'h00);
        check("skew_dout", dout_a, 8'hF0);
        $display("txn skew: dout=%h pulses=%0d", dout_a, pulses_a);

        din_a = 8'h3C;
        repeat (5) tick();
        rst_n = 1'b0;
        tick();
        check("midrst_dout", dout_a, 8'h00);
        check("midrst_vld", {7'b0, vld_a}, 8'h00);
        check("midrst_unst", {7'b0, unst_a}, 8'h01);
        rst_n = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick();
            if (e == 6) check("midrst_dout_e6", dout_a, 8'h00);
            if (e == 6) check("midrst_vld_e6", {7'b0, vld_a}, 8'h00);
            if (e == 7) check("midrst_dout_e7", dout_a, 8'h3C);
            if (e == 7) check("midrst_chg_e7", {7'b0, chg_a}, 8'h01);
            if (e == 7) check("midrst_vld_e7", {7'b0, vld_a}, 8'h01);
        end
        $display("txn midreset_3C: dout=%h vld=%b", dout_a, vld_a);

        din_b = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            tick();
            if (e == 5) check("b_step_dout_e5", {7'b0, dout_b}, 8'h00);
            if (e == 6) check("b_step_dout_e6", {7'b0, dout_b}, 8'h01);
            if (e == 6) check("b_step_chg_e6", {7'b0, chg_b}, 8'h01);
        end
        $display("txn b_step: dout=%b", dout_b);
        repeat (4) tick();

        pulses_b = 0;
        din_b = 1'b0; run(1);
        din_b = 1'b1; run(10);
        check("b_pulse1_pulses", 8'(pulses_b), 8'd0);
        check("b_pulse1_dout", {7'b0, dout_b}, 8'h01);
        $display("txn b_pulse1: dout=%b pulses=%0d", dout_b, pulses_b);

        pulses_b = 0;
        din_b = 1'b0; run(2);
        din_b = 1'b1; run(10);
        check("b_pulse2_pulses", 8'(pulses_b), 8'd2);
        check("b_pulse2_dout", {7'b0, dout_b}, 8'h01);
        $display("txn b_pulse2: dout=%b pulses=%0d", dout_b, pulses_b);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
